// File: rtl/guess_sweep_ctrl_if.sv
// Handshake and result bundle between guess_sweep_ctrl and its environment.
// master = the sweep controller, slave = stimulus/transmitter/observer side.
interface guess_sweep_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             START;
    logic [7:0]       DATA_IN;
    logic             TX_ACK;
    logic             TX_REQ;
    logic [7:0]       TX_BYTE;
    logic             BUSY;
    logic             DONE;
    logic             FOUND;
    logic [7:0]       BEST_BYTE;
    logic [CNT_W+1:0] BEST_CYC;
    logic [7:0]       TO_CNT;

    modport master (
        input  START, DATA_IN, TX_ACK,
        output TX_REQ, TX_BYTE, BUSY, DONE, FOUND, BEST_BYTE, BEST_CYC, TO_CNT
    );

    modport slave (
        output START, DATA_IN, TX_ACK,
        input  TX_REQ, TX_BYTE, BUSY, DONE, FOUND, BEST_BYTE, BEST_CYC, TO_CNT
    );
endinterface

// File: rtl/guess_sweep_ctrl.sv
// Sweeps candidate bytes through a transmitter and keeps the guess with the longest NO latency.
// Optional macro GUESS_AVG4_EN: each guess is framed 4 times and the latencies are summed.
//
// state      | meaning
// S_IDLE     | waiting for START, results held
// S_ISSUE    | one-cycle frame request for the current guess
// S_WAIT_ACK | waiting for the transmitter to finish the frame
// S_MEASURE  | counting reply latency, watching for YES/NO/timeout
// S_RECORD   | compare metric against best, advance guess
// S_FINISH   | one-cycle DONE pulse
module guess_sweep_ctrl #(
    parameter logic [7:0]  FIRST_GUESS = 8'h06,
    parameter logic [7:0]  LAST_GUESS  = 8'hFF,
    parameter int          CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 16'hFFFF
) (
    input logic                CLK_50,
    input logic                RST_N,
    guess_sweep_ctrl_if.master bus
);
    localparam int               MW       = CNT_W + 2;
    localparam logic [7:0]       BYTE_YES = 8'h03;
    localparam logic [7:0]       BYTE_NO  = 8'h04;
    localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT_CYC);
`ifdef GUESS_AVG4_EN
    localparam logic [1:0]       LAST_REP = 2'd3;
`else
    localparam logic [1:0]       LAST_REP = 2'd0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_ACK, S_MEASURE, S_RECORD, S_FINISH
    } state_t;

    state_t           state, state_next;
    logic [7:0]       guess;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic [MW-1:0]    sum, sum_next;
    logic [1:0]       rep;
    logic             skip;
    logic             found;
    logic [7:0]       best_byte;
    logic [MW-1:0]    best_cyc;
    logic [7:0]       to_cnt;
    logic             is_yes, is_no, is_to;

    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        cnt_inc    = (&cnt) ? cnt : cnt + 1'b1;
        is_yes     = (bus.DATA_IN == BYTE_YES);
        is_no      = (bus.DATA_IN == BYTE_NO);
        // a reply arriving on the timeout cycle itself still wins
        is_to      = !is_yes && !is_no && (cnt_inc == TO_LIM);
        sum_next   = sum + MW'(cnt_inc);
        state_next = state;
        case (state)
            S_IDLE:     if (bus.START) state_next = S_ISSUE;
            S_ISSUE:    state_next = S_WAIT_ACK;
            S_WAIT_ACK: if (bus.TX_ACK) state_next = S_MEASURE;
            S_MEASURE: begin
                if (is_yes)     state_next = S_FINISH;
                else if (is_to) state_next = S_RECORD;
                else if (is_no) state_next = (rep == LAST_REP) ? S_RECORD : S_ISSUE;
            end
            S_RECORD:   state_next = (guess == LAST_GUESS) ? S_FINISH : S_ISSUE;
            S_FINISH:   state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            guess     <= FIRST_GUESS;
            cnt       <= '0;
            sum       <= '0;
            rep       <= '0;
            skip      <= 1'b0;
            found     <= 1'b0;
            best_byte <= '0;
            best_cyc  <= '0;
            to_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.START) begin
                        guess     <= FIRST_GUESS;
                        sum       <= '0;
                        rep       <= '0;
                        skip      <= 1'b0;
                        found     <= 1'b0;
                        best_byte <= '0;
                        best_cyc  <= '0;
                        to_cnt    <= '0;
                    end
                end
                S_WAIT_ACK: if (bus.TX_ACK) cnt <= '0;
                S_MEASURE: begin
                    cnt <= cnt_inc;
                    if (is_yes) begin
                        best_byte <= guess;
                        best_cyc  <= MW'(cnt_inc);
                        found     <= 1'b1;
                    end else if (is_no) begin
                        sum <= sum_next;
                        rep <= rep + 2'd1;
                    end else if (is_to) begin
                        skip <= 1'b1;
                        if (to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
                    end
                end
                S_RECORD: begin
                    // strict compare so ties keep the earlier guess
                    if (!skip && (sum > best_cyc)) begin
                        best_byte <= guess;
                        best_cyc  <= sum;
                    end
                    if (guess != LAST_GUESS) guess <= guess + 8'd1;
                    sum  <= '0;
                    rep  <= '0;
                    skip <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.TX_REQ    = (state == S_ISSUE);
    assign bus.TX_BYTE   = guess;
    assign bus.BUSY      = (state != S_IDLE);
    assign bus.DONE      = (state == S_FINISH);
    assign bus.FOUND     = found;
    assign bus.BEST_BYTE = best_byte;
    assign bus.BEST_CYC  = best_cyc;
    assign bus.TO_CNT    = to_cnt;
endmodule

// File: doc/guess_sweep_ctrl.md
GUESS_SWEEP_CTRL -- requirements
Module: guess_sweep_ctrl

Interface
REQ-001 SHALL have parameter FIRST_GUESS, default 8'h06: first candidate byte issued.
REQ-002 SHALL have parameter LAST_GUESS, default 8'hFF: final candidate byte; LAST_GUESS >= FIRST_GUESS.
REQ-003 SHALL have parameter CNT_W, default 16: latency counter width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 16'hFFFF: maximum reply wait in cycles, at most 2^CNT_W-1.
REQ-005 SHALL have port CLK_50, input, 1 bit: the single clock.
REQ-006 SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port START, input, 1 bit: one-cycle pulse that begins a sweep.
REQ-008 SHALL have port DATA_IN, input, 8 bits: reply byte from the CM bus interface.
REQ-009 SHALL have port TX_ACK, input, 1 bit: one-cycle pulse when the transmitter has finished the START/guess/END frame.
REQ-010 SHALL have port TX_REQ, output, 1 bit: frame request to the transmitter.
REQ-011 SHALL have port TX_BYTE, output, 8 bits: guess byte for the frame.
REQ-012 SHALL have port BUSY, output, 1 bit: high while a sweep is in progress.
REQ-013 SHALL have port DONE, output, 1 bit: one-cycle pulse at sweep end.
REQ-014 SHALL have port FOUND, output, 1 bit: sweep ended on a YES reply.
REQ-015 SHALL have port BEST_BYTE, output, 8 bits: guess with the longest NO latency, or the YES guess.
REQ-016 SHALL have port BEST_CYC, output, CNT_W+2 bits: latency metric of BEST_BYTE.
REQ-017 SHALL have port TO_CNT, output, 8 bits: number of timeouts in the sweep, saturating at 255.

Function
REQ-018 SHALL implement the states IDLE, ISSUE, WAIT_ACK, MEASURE, RECORD and FINISH.
REQ-019 SHALL go IDLE->ISSUE on START: guess:=FIRST_GUESS; best, TO_CNT and FOUND cleared.
REQ-020 SHALL, in ISSUE, assert TX_REQ with TX_BYTE=guess for exactly one cycle, then go to WAIT_ACK.
REQ-021 SHALL stay in WAIT_ACK with TX_REQ low until TX_ACK; on TX_ACK, clear the counter and go to MEASURE.
REQ-022 SHALL, in MEASURE, count once per cycle starting at 1 on the first MEASURE cycle, saturating at all-ones.
REQ-023 SHALL treat DATA_IN==8'h03 (YES) in MEASURE as: BEST_BYTE:=guess, BEST_CYC:=count, FOUND:=1, go to FINISH.
REQ-024 SHALL treat DATA_IN==8'h04 (NO) in MEASURE as: latch count, go to RECORD.
REQ-025 SHALL treat count==TIMEOUT_CYC with no YES/NO as: increment TO_CNT, go to RECORD without updating best.
REQ-026 SHALL ignore all other DATA_IN values in MEASURE.
REQ-027 SHALL, in RECORD, update best to (guess, metric) if metric > BEST_CYC, with ties keeping the earlier guess.
REQ-028 SHALL, in RECORD, go to FINISH if guess==LAST_GUESS, else increment guess and go to ISSUE.
REQ-029 SHALL never wrap the guess past LAST_GUESS (8'hFF does not roll over to 8'h00).
REQ-030 SHALL, in FINISH, pulse DONE for 1 cycle and go to IDLE; results hold until the next START.
REQ-031 SHALL have BUSY = state != IDLE.
REQ-032 SHALL ignore START while BUSY.
REQ-033 SHALL, if TX_ACK and a YES/NO both arrive in WAIT_ACK, accept only TX_ACK; replies before ACK are discarded.

Reset
REQ-034 SHALL, on RST_N low (asynchronous, any state, including mid-frame), set state=IDLE, TX_REQ=0, TX_BYTE=FIRST_GUESS, BUSY=0, DONE=0, FOUND=0, BEST_BYTE=0, BEST_CYC=0, TO_CNT=0, counter=0.
REQ-035 SHALL leave reset synchronously on the first CLK_50 edge after RST_N rises; a frame aborted by reset is not re-issued.

Configuration
REQ-036 SHALL, with GUESS_AVG4_EN defined, issue each guess 4 times (ISSUE..MEASURE x4) and use the sum of the 4 latencies (CNT_W+2 bits) as the metric.
REQ-037 SHALL, with GUESS_AVG4_EN defined, finish immediately on YES in any repetition, and count a timeout in any repetition once into TO_CNT and discard that guess.
REQ-038 SHALL, with GUESS_AVG4_EN undefined, issue each guess once, with the metric zero-extended to CNT_W+2 bits.

Verification
REQ-039 SHALL cover: FIRST=6, LAST=8, NO replies at latencies 10/25/12 -> DONE, FOUND=0, BEST_BYTE=7, BEST_CYC=25, TO_CNT=0.
REQ-040 SHALL cover: YES on guess 9 at latency 40 -> FOUND=1, BEST_BYTE=9, BEST_CYC=40, no TX_REQ for 10.
REQ-041 SHALL cover: TIMEOUT_CYC=50, no reply on guess 6 -> RECORD at count 50, TO_CNT=1, best unchanged, guess 7 issued.
REQ-042 SHALL cover: LAST=8'hFF, FIRST=8'hFE -> exactly 2 TX_REQ pulses, DONE after guess FF, TX_BYTE never 00.
REQ-043 SHALL cover: RST_N low during MEASURE of guess 7 -> all outputs at reset values immediately; START afterwards reissues 6.
REQ-044 SHALL cover: GUESS_AVG4_EN, latencies 10,11,12,13 on guess 6 -> 4 TX_REQ pulses, BEST_CYC=46.
